// File: rtl/lram_obj_sequencer_if.sv
// Object-descriptor and graphics-byte handshake between the DMA /
// display-list fetcher (master) and the line-RAM sequencer (slave).
//
// Signals:
//   obj_valid/obj_ready  descriptor handshake (accepted when both high)
//   obj_hpos[7:0]        object start cell
//   obj_palette[2:0]     palette
//   obj_wm               write mode (0: 4 cells/byte, 1: 2 cells/byte)
//   obj_width[4:0]       byte count, 0 encodes 32
//   pix_valid/pix_ready  graphics-byte handshake (accepted when both high)
//   pix_data[7:0]        graphics byte
interface lram_obj_sequencer_if;
  logic       obj_valid;
  logic       obj_ready;
  logic [7:0] obj_hpos;
  logic [2:0] obj_palette;
  logic       obj_wm;
  logic [4:0] obj_width;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;

  modport master (
    output obj_valid, obj_hpos, obj_palette, obj_wm, obj_width,
    output pix_valid, pix_data,
    input  obj_ready, pix_ready
  );

  modport slave (
    input  obj_valid, obj_hpos, obj_palette, obj_wm, obj_width,
    input  pix_valid, pix_data,
    output obj_ready, pix_ready
  );
endinterface

// File: rtl/lram_obj_sequencer.sv
// MARIA line-RAM write sequencer. Takes object descriptors and their
// graphics-byte stream from the DMA engine, drives line_ram's
// hpos/PALETTE/WM/PIXELS with latch_byte and clear_hpos strobes, and
// issues lrc (buffer swap) at each line start. All state advances on
// mclk1 ticks, so outputs are stable whenever line_ram samples on mclk0.
//
// Ports:
//   clk_sys, RESET_N  clock, async active-low reset
//   mclk0             line_ram sample strobe (not used internally)
//   mclk1             sequencer tick strobe
//   line_start        1-cycle line start pulse, any clk_sys cycle
//   dma               obj/pix handshake (lram_obj_sequencer_if.slave)
//   hpos, PALETTE, WM, PIXELS, latch_byte, clear_hpos, lrc  to line_ram
//   busy              state != IDLE or swap pending
//   overrun_cnt       objects aborted by line_start
//
// Build option:
//   LRAM_OVERRUN_CNT_EN  when defined, overrun_cnt counts aborts from
//                        LOAD/STREAM (saturating at 255, cleared by reset
//                        only); otherwise overrun_cnt is tied to zero.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a descriptor or a pending line swap
// LOAD   | descriptor latched, clear_hpos pulse to line_ram
// STREAM | consuming graphics bytes, one latch_byte per accepted byte
// SWAP   | lrc pulse to line_ram, back to IDLE on the next tick
module lram_obj_sequencer #(
  parameter int MAX_W = 32
) (
  input  logic                       clk_sys,
  input  logic                       RESET_N,
  input  logic                       mclk0,
  input  logic                       mclk1,
  input  logic                       line_start,
  lram_obj_sequencer_if.slave        dma,
  output logic [7:0]                 hpos,
  output logic [2:0]                 PALETTE,
  output logic                       WM,
  output logic [7:0]                 PIXELS,
  output logic                       latch_byte,
  output logic                       clear_hpos,
  output logic                       lrc,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_SWAP   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [5:0] count_q, count_d;
  logic [7:0] hpos_q, hpos_d;
  logic [2:0] pal_q, pal_d;
  logic       wm_q, wm_d;
  logic [7:0] pix_q, pix_d;
  logic       latch_q, latch_d;
  logic       clear_q, clear_d;
  logic       lrc_q, lrc_d;
  logic       obj_acc, pix_acc, swap_enter;

  // mclk0 is only a timing contract with line_ram: because everything here
  // moves on mclk1, outputs are already settled when mclk0 arrives.
  logic unused_mclk0;
  assign unused_mclk0 = mclk0;

  // A line_start in the same cycle blocks the handshake so it can win.
  assign dma.obj_ready = RESET_N & mclk1 & (state_q == S_IDLE)
                         & ~pending_q & ~line_start;
  assign dma.pix_ready = RESET_N & mclk1 & (state_q == S_STREAM)
                         & ~pending_q & ~line_start;

  assign obj_acc = dma.obj_valid & dma.obj_ready;
  assign pix_acc = dma.pix_valid & dma.pix_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hpos_d     = hpos_q;
    pal_d      = pal_q;
    wm_d       = wm_q;
    pix_d      = pix_q;
    latch_d    = latch_q;
    clear_d    = clear_q;
    lrc_d      = lrc_q;
    swap_enter = 1'b0;

    if (mclk1) begin
      // Strobes are one tick wide: drop them every tick unless re-asserted.
      latch_d = 1'b0;
      clear_d = 1'b0;
      lrc_d   = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            swap_enter = 1'b1;
          end else if (obj_acc) begin
            hpos_d  = dma.obj_hpos;
            pal_d   = dma.obj_palette;
            wm_d    = dma.obj_wm;
            count_d = (dma.obj_width == 5'd0) ? 6'(MAX_W) : {1'b0, dma.obj_width};
            clear_d = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (pending_q) begin
            swap_enter = 1'b1;
          end else begin
            state_d = S_STREAM;
          end
        end
        S_STREAM: begin
          if (pending_q) begin
            swap_enter = 1'b1;
          end else if (pix_acc) begin
            pix_d   = dma.pix_data;
            latch_d = 1'b1;
            count_d = count_q - 6'd1;
            if (count_q == 6'd1) begin
              state_d = S_IDLE;
            end
          end
        end
        S_SWAP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (swap_enter) begin
        lrc_d   = 1'b1;
        state_d = S_SWAP;
      end
    end
  end

  // A new line_start in the very tick that enters SWAP must survive, so
  // that it produces a second swap.
  assign pending_d = line_start | (pending_q & ~swap_enter);

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      count_q   <= 6'd0;
      hpos_q    <= 8'd0;
      pal_q     <= 3'd0;
      wm_q      <= 1'b0;
      pix_q     <= 8'd0;
      latch_q   <= 1'b0;
      clear_q   <= 1'b0;
      lrc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      hpos_q    <= hpos_d;
      pal_q     <= pal_d;
      wm_q      <= wm_d;
      pix_q     <= pix_d;
      latch_q   <= latch_d;
      clear_q   <= clear_d;
      lrc_q     <= lrc_d;
    end
  end

`ifdef LRAM_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;
  logic       ovr_inc;

  // An abort is a pending swap taken from LOAD or STREAM.
  assign ovr_inc = mclk1 & pending_q & ((state_q == S_LOAD) | (state_q == S_STREAM));

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_inc && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      ovr_q <= 8'd0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign hpos       = hpos_q;
  assign PALETTE    = pal_q;
  assign WM         = wm_q;
  assign PIXELS     = pix_q;
  assign latch_byte = latch_q;
  assign clear_hpos = clear_q;
  assign lrc        = lrc_q;
  assign busy       = (state_q != S_IDLE) | pending_q;

endmodule

// File: tb/tb_lram_obj_sequencer.sv
// Bench for lram_obj_sequencer. The reference is an event-level model:
// every object is expected to produce one clear_hpos event carrying its
// hpos/palette/wm, then one latch_byte event per consumed byte; every line
// start produces one lrc event. A monitor samples the outputs after each
// mclk1 tick and matches them in order against the expected-event queue.
module tb_lram_obj_sequencer;
  logic       clk_sys = 1'b0;
  logic       RESET_N = 1'b0;
  logic       mclk0 = 1'b0;
  logic       mclk1 = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] hpos, PIXELS, overrun_cnt;
  logic [2:0] PALETTE;
  logic       WM, latch_byte, clear_hpos, lrc, busy;

  lram_obj_sequencer_if dma_if();

  lram_obj_sequencer dut (
    .clk_sys     (clk_sys),
    .RESET_N     (RESET_N),
    .mclk0       (mclk0),
    .mclk1       (mclk1),
    .line_start  (line_start),
    .dma         (dma_if),
    .hpos        (hpos),
    .PALETTE     (PALETTE),
    .WM          (WM),
    .PIXELS      (PIXELS),
    .latch_byte  (latch_byte),
    .clear_hpos  (clear_hpos),
    .lrc         (lrc),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int         total = 0;
  int         bad = 0;
  int         ph = 0;
  int         tick_n = 0;
  int         clr_tick = 0;
  int         lrc_tick = 0;
  int         ls_tick = 0;
  int         exp_ovr = 0;
  int         lat_ticks[$];
  logic [21:0] exp_q[$];
  logic [7:0] src[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic mon_evt(input logic [21:0] act);
    logic [21:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 22'h0;
    check("event", {10'h0, act}, {10'h0, exp});
  endtask

  // Monitor: one sample per tick, after the registers have updated.
  always @(posedge clk_sys) begin
    if (RESET_N && mclk1) begin
      #1;
      tick_n++;
      check("one_hot", ((int'(latch_byte) + int'(clear_hpos) + int'(lrc)) <= 1), 1);
      if (clear_hpos) begin
        clr_tick = tick_n;
        mon_evt({2'd1, WM, PALETTE, hpos, 8'h00});
      end
      if (latch_byte) begin
        lat_ticks.push_back(tick_n);
        mon_evt({2'd2, WM, PALETTE, hpos, PIXELS});
      end
      if (lrc) begin
        lrc_tick = tick_n;
        mon_evt({2'd3, 20'h0});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One clk_sys cycle: advance the strobe phase, drop the line_start pulse.
  task automatic step();
    @(negedge clk_sys);
    ph = (ph == 3) ? 0 : ph + 1;
    mclk1 = (ph == 0);
    mclk0 = (ph == 2);
    line_start = 1'b0;
  endtask

  // Leaves us just before the next tick edge.
  task automatic wait_tick();
    do step(); while (!mclk1);
  endtask

  task automatic count_abort();
`ifdef LRAM_OVERRUN_CNT_EN
    if (exp_ovr < 255) exp_ovr++;
`endif
  endtask

  task automatic offer_obj(input logic [7:0] h, input logic [2:0] p, input logic wm,
                           input logic [4:0] w, input bit ls);
    int i;
    dma_if.obj_hpos    = h;
    dma_if.obj_palette = p;
    dma_if.obj_wm      = wm;
    dma_if.obj_width   = w;
    if (ls) begin
      wait_tick();
      dma_if.obj_valid = 1'b1;
      line_start = 1'b1;
      ls_tick = tick_n + 1;
      #1;
      check("ls_wins", dma_if.obj_ready, 0);
      exp_q.push_back({2'd3, 20'h0});
      step();
    end
    for (i = 0; i < 200; i++) begin
      wait_tick();
      dma_if.obj_valid = 1'b1;
      #1;
      if (dma_if.obj_ready) break;
    end
    if (i == 200) check("obj_timeout", dma_if.obj_ready, 1);
    else exp_q.push_back({2'd1, wm, p, h, 8'h00});
    step();
    dma_if.obj_valid = 1'b0;
  endtask

  task automatic offer_byte(input logic [7:0] b, input logic [7:0] h, input logic [2:0] p,
                            input logic wm);
    int i;
    for (i = 0; i < 200; i++) begin
      wait_tick();
      dma_if.pix_valid = 1'b1;
      dma_if.pix_data  = b;
      #1;
      if (dma_if.pix_ready) break;
    end
    if (i == 200) check("pix_timeout", dma_if.pix_ready, 1);
    else exp_q.push_back({2'd2, wm, p, h, b});
    step();
    dma_if.pix_valid = 1'b0;
  endtask

  // Sends one object from src[]; abort_k >= 0 raises line_start at the tick
  // byte abort_k would be offered.
  task automatic send_obj(input logic [7:0] h, input logic [2:0] p, input logic wm,
                          input logic [4:0] w, input int abort_k, input int bubble_at,
                          input int bubble_pct, input bit ls);
    int n;
    n = (w == 5'd0) ? 32 : int'(w);
    offer_obj(h, p, wm, w, ls);
    for (int i = 0; i < n; i++) begin
      if (i == abort_k) begin
        wait_tick();
        dma_if.pix_valid = 1'b1;
        dma_if.pix_data  = src[i];
        line_start = 1'b1;
        #1;
        check("abort_nacc", dma_if.pix_ready, 0);
        exp_q.push_back({2'd3, 20'h0});
        count_abort();
        step();
        dma_if.pix_valid = 1'b0;
        break;
      end
      if (i == bubble_at) begin
        repeat (2) wait_tick();
      end else if (i > 0 && $urandom_range(0, 99) < bubble_pct) begin
        repeat ($urandom_range(1, 2)) wait_tick();
      end
      offer_byte(src[i], h, p, wm);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      step();
      #1;
      if (!busy) break;
    end
    check("idle", busy, 0);
    check("ovr", overrun_cnt, exp_ovr);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [4:0] w;
    int n, k;
    dma_if.obj_valid = 1'b0; dma_if.obj_hpos = 8'h0; dma_if.obj_palette = 3'h0;
    dma_if.obj_wm = 1'b0; dma_if.obj_width = 5'h0;
    dma_if.pix_valid = 1'b0; dma_if.pix_data = 8'h0;

    // Reset state
    repeat (4) step();
    #1;
    check("rst_out", {hpos, PALETTE, WM, PIXELS, latch_byte, clear_hpos, lrc, busy, overrun_cnt}, 0);
    step();
    RESET_N = 1'b1;
    wait_tick();
    #1;
    check("rst_ready", dma_if.obj_ready, 1);

    // Basic 3-byte object, no bubbles
    src.delete(); src.push_back(8'hAA); src.push_back(8'h55); src.push_back(8'hFF);
    lat_ticks.delete();
    send_obj(8'h10, 3'd5, 1'b0, 5'd3, -1, -1, 0, 1'b0);
    wait_tick();
    #1;
    check("ready_after", dma_if.obj_ready, 1);
    check("lat0", lat_ticks[0], clr_tick + 2);
    check("lat1", lat_ticks[1], clr_tick + 3);
    check("lat2", lat_ticks[2], clr_tick + 4);
    check("hpos_held", hpos, 8'h10);
    wait_idle();

    // width 0 -> 32 bytes, 2-tick gap before byte 10
    fill_src(32);
    lat_ticks.delete();
    send_obj(8'hF0, 3'd2, 1'b1, 5'd0, -1, 10, 0, 1'b0);
    wait_idle();
    check("w32_count", lat_ticks.size(), 32);
    check("gap", lat_ticks[10] - lat_ticks[9], 3);
    check("nogap", lat_ticks[9] - lat_ticks[8], 1);

    // line_start during byte 2 of a 4-byte object
    fill_src(4);
    send_obj(8'h33, 3'd1, 1'b0, 5'd4, 2, -1, 0, 1'b0);
    wait_idle();

    // line_start in the same tick as a descriptor
    fill_src(2);
    send_obj(8'h44, 3'd7, 1'b1, 5'd2, -1, -1, 0, 1'b1);
    wait_idle();
    check("lrc_next", lrc_tick, ls_tick + 1);

    // Two line starts three ticks apart while idle
    step();
    line_start = 1'b1;
    exp_q.push_back({2'd3, 20'h0});
    repeat (3) wait_tick();
    step();
    line_start = 1'b1;
    exp_q.push_back({2'd3, 20'h0});
    wait_idle();

    // Reset mid-STREAM
    fill_src(8);
    offer_obj(8'h77, 3'd3, 1'b1, 5'd8, 1'b0);
    offer_byte(src[0], 8'h77, 3'd3, 1'b1);
    offer_byte(src[1], 8'h77, 3'd3, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("rst_mid", {hpos, PALETTE, WM, PIXELS, latch_byte, clear_hpos, lrc, busy, overrun_cnt}, 0);
    check("rst_mid_q", exp_q.size(), 0);
    exp_q.delete();
    exp_ovr = 0;
    repeat (3) step();
    RESET_N = 1'b1;
    wait_tick();
    #1;
    check("rst_rel_ready", dma_if.obj_ready, 1);
    check("rst_rel_busy", busy, 0);

    // Randomized objects, bubbles, aborts and idle line starts
    for (int t = 0; t < 30; t++) begin
      w = 5'($urandom_range(0, 31));
      n = (w == 5'd0) ? 32 : int'(w);
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      fill_src(n);
      send_obj(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               w, k, -1, 20, 1'b0);
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        step();
        line_start = 1'b1;
        exp_q.push_back({2'd3, 20'h0});
        wait_idle();
      end
    end

    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
